// File: rtl/pc_1.sv
// pc_1 - program-counter register for the cpu1 core (backs register r15).
//
// A single WIDTH-bit register. Update priority at each rising clock edge:
// reset, then a load from din (wen), then an increment by one (cen),
// otherwise hold. dout is driven straight from the register with no bypass,
// so a load or increment is visible on dout one cycle after its edge.
//
// Optional build macro: PC_WRAP_DETECT_EN
//   When defined, adds a registered one-bit output 'wrap'. It is high for
//   exactly the cycle after an increment that rolled the PC over from
//   all-ones to zero. A load of zero does not raise it.
//   When undefined, the port and its logic do not exist; dout is unchanged.
module pc_1 #(
  parameter int                 WIDTH       = 32,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cen,
  input  logic               wen,
  input  logic [WIDTH-1:0]   din,
`ifdef PC_WRAP_DETECT_EN
  output logic [WIDTH-1:0]   dout,
  output logic               wrap
`else
  output logic [WIDTH-1:0]   dout
`endif
);

  // Initialiser gives the register a defined power-up value before the
  // first reset edge; FPGA flows map it to the flop's init value.
  logic [WIDTH-1:0] pc_reg = RESET_VALUE;
  logic [WIDTH-1:0] pc_next;

  // An increment out of the all-ones value is the only way to wrap; the
  // carry out of the adder is simply dropped.
  logic             pc_all_ones;
  assign pc_all_ones = (pc_reg == {WIDTH{1'b1}});

  // Next-state selection: load beats increment; reset is applied in the
  // register process so it overrides both.
  always_comb begin
    pc_next = pc_reg;
    if (wen) begin
      pc_next = din;
    end else if (cen) begin
      pc_next = pc_reg + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // PC register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= RESET_VALUE;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign dout = pc_reg;

`ifdef PC_WRAP_DETECT_EN
  logic wrap_reg  = 1'b0;
  logic wrap_next;

  // Wrap flag is set only by a genuine increment out of all-ones.
  always_comb begin
    wrap_next = 1'b0;
    if (!wen && cen && pc_all_ones) begin
      wrap_next = 1'b1;
    end
  end

  // Wrap flag register; clears on reset and on every non-wrapping cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= wrap_next;
    end
  end

  assign wrap = wrap_reg;
`else
  // Keep the all-ones detect referenced in the default build so it does
  // not dangle; it folds away during synthesis.
  logic unused_all_ones;
  assign unused_all_ones = pc_all_ones;
`endif

endmodule

// File: tb/tb_pc_1.sv
// tb_pc_1 - self-checking bench for pc_1 (WIDTH=32, RESET_VALUE=0).
// Each transaction pushes the expected post-edge PC (and wrap flag) into a
// scoreboard queue when its inputs are driven; the entry is popped and
// compared after the clock edge. Define PC_WRAP_DETECT_EN to also check wrap.
module tb_pc_1;
  localparam int W = 32;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         cen   = 1'b0;
  logic         wen   = 1'b0;
  logic [W-1:0] din   = '0;
  logic [W-1:0] dout;
`ifdef PC_WRAP_DETECT_EN
  logic         wrap;
`endif

  pc_1 #(.WIDTH(W), .RESET_VALUE(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .cen   (cen),
    .wen   (wen),
    .din   (din),
`ifdef PC_WRAP_DETECT_EN
    .dout  (dout),
    .wrap  (wrap)
`else
    .dout  (dout)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] model_pc = '0;
  logic [W-1:0] exp_pc_q[$];
  logic         exp_wrap_q[$];

  task automatic check_eq(input string tag, input logic [W-1:0] got,
                          input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock transaction: drive inputs, score expected result, clock, compare.
  task automatic step(input string tag, input logic r, input logic c,
                      input logic w, input logic [W-1:0] d);
    logic [W-1:0] nxt;
    logic         nwrap;
    logic [W-1:0] e_pc;
    logic         e_wrap;
    reset = r; cen = c; wen = w; din = d;
    #1;
    // No bypass: new inputs must not show on dout before the edge.
    check_eq({tag, "/nobypass"}, dout, model_pc);
    if (r)      nxt = '0;
    else if (w) nxt = d;
    else if (c) nxt = model_pc + 32'd1;
    else        nxt = model_pc;
    nwrap = !r && !w && c && (model_pc == 32'hFFFF_FFFF);
    exp_pc_q.push_back(nxt);
    exp_wrap_q.push_back(nwrap);
    model_pc = nxt;
    @(posedge clk);
    #1;
    if (exp_pc_q.size() == 0) begin
      check_eq({tag, "/sb_empty"}, 32'd0, 32'd1);
    end else begin
      e_pc   = exp_pc_q.pop_front();
      e_wrap = exp_wrap_q.pop_front();
      check_eq(tag, dout, e_pc);
`ifdef PC_WRAP_DETECT_EN
      check_eq({tag, "/wrap"}, {31'b0, wrap}, {31'b0, e_wrap});
`endif
      $display("txn %-10s reset=%0b cen=%0b wen=%0b din=0x%08h dout=0x%08h exp=0x%08h wrap_exp=%0b",
               tag, r, c, w, d, dout, e_pc, e_wrap);
    end
  endtask

  initial begin
    #1;
    check_eq("powerup", dout, 32'h0);

    // 1: reset overrides load and increment
    step("reset", 1'b1, 1'b1, 1'b1, 32'h55);

    // 2: count five, then hold three
    for (int i = 0; i < 5; i++) step("count", 1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("count_is_5", dout, 32'd5);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    check_eq("hold_is_5", dout, 32'd5);

    // 3: load then increment
    step("load", 1'b0, 1'b0, 1'b1, 32'h0000_1000);
    check_eq("load_1000", dout, 32'h1000);
    step("inc", 1'b0, 1'b1, 1'b0, 32'h0);
    step("inc", 1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("inc_1002", dout, 32'h1002);

    // 4: load beats increment on the same edge
    step("load+cen", 1'b0, 1'b1, 1'b1, 32'h0000_0200);
    check_eq("prio_200", dout, 32'h200);

    // 5: wrap from all-ones, then wrap drops
    step("load_max", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    step("wrap_inc", 1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("wrap_to_0", dout, 32'h0);
    step("post_wrap", 1'b0, 1'b0, 1'b0, 32'h0);
    // a load of zero from all-ones is not a wrap
    step("load_max", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    step("load_zero", 1'b0, 1'b1, 1'b1, 32'h0);
    // reset at all-ones with cen is not a wrap either
    step("load_max", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    step("rst_max", 1'b1, 1'b1, 1'b0, 32'h0);

    // 6: reset in the middle of a counting run
    step("load", 1'b0, 1'b0, 1'b1, 32'h0000_003E);
    step("inc", 1'b0, 1'b1, 1'b0, 32'h0);
    step("inc", 1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("at_40", dout, 32'h40);
    step("mid_reset", 1'b1, 1'b1, 1'b0, 32'h0);
    step("resume", 1'b0, 1'b1, 1'b0, 32'h0);
    step("resume", 1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("resume_2", dout, 32'h2);

    // Random mix, biased toward loads near the wrap point
    for (int i = 0; i < 60; i++) begin
      logic         r, c, w;
      logic [W-1:0] d;
      r = ($urandom_range(0, 15) == 0);
      c = $urandom_range(0, 3) != 0;
      w = ($urandom_range(0, 4) == 0);
      d = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFE : W'($urandom);
      step("rand", r, c, w, d);
    end

    check_eq("sb_drained", W'(exp_pc_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
